// File: rtl/semaforo_temporizado.sv
// -----------------------------------------------------------------------------
// semaforo_temporizado
//
// Timed two-way traffic-light controller.  A Moore FSM alternates green
// between north-south (NS) and east-west (LO).  Each green holds for at least
// T_VERDE_MIN tick-enabled cycles.  It then waits for a green request from the
// other direction.  Amber lasts exactly T_AMARELO tick-enabled cycles.
//
// Optional feature (macro VERMELHO_TOTAL_EN):
//   When the macro is defined, an all-red clearance phase of T_VERMELHO
//   tick-enabled cycles is inserted after each amber.  When it is undefined,
//   amber hands over directly to the opposite green.
//
// Parameters:
//   T_VERDE_MIN  minimum green duration, 1..255
//   T_AMARELO    amber duration, 1..255
//   T_VERMELHO   all-red duration, 1..255 (only used with VERMELHO_TOTAL_EN)
//
// Ports:
//   clk          single clock, rising-edge
//   rst          asynchronous active-high reset (forces LO_VERDE)
//   tick         time-base enable; the phase timer only advances when tick=1
//   n_s          north-south green request (sampled, not latched)
//   l_o          east-west green request (sampled, not latched)
//   ns_verde/ns_amarelo/ns_vermelho   north-south lamp drives (registered)
//   lo_verde/lo_amarelo/lo_vermelho   east-west lamp drives (registered)
//   estado       current state code (the state register)
// -----------------------------------------------------------------------------
module semaforo_temporizado #(
    parameter int T_VERDE_MIN = 8,
    parameter int T_AMARELO   = 3,
    parameter int T_VERMELHO  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       n_s,
    input  logic       l_o,
    output logic       ns_verde,
    output logic       ns_amarelo,
    output logic       ns_vermelho,
    output logic       lo_verde,
    output logic       lo_amarelo,
    output logic       lo_vermelho,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        NS_VERDE   = 3'd0,
        NS_AMARELO = 3'd1,
        VERM_A     = 3'd2,
        LO_VERDE   = 3'd3,
        LO_AMARELO = 3'd4,
        VERM_B     = 3'd5
    } estado_t;

    // Terminal timer values.  The timer counts from 0, so a phase of N
    // tick-enabled cycles ends on the edge where the timer reads N-1.
    localparam logic [7:0] VERDE_LIM    = 8'(T_VERDE_MIN - 1);
    localparam logic [7:0] AMARELO_LIM  = 8'(T_AMARELO - 1);
    localparam logic [7:0] VERMELHO_LIM = 8'(T_VERMELHO - 1);
    localparam logic [7:0] TIMER_MAX    = 8'd255;

    // Lamp vector order: {ns_verde, ns_amarelo, ns_vermelho,
    //                     lo_verde, lo_amarelo, lo_vermelho}
    localparam logic [5:0] LAMPS_NS_VERDE   = 6'b100_001;
    localparam logic [5:0] LAMPS_NS_AMARELO = 6'b010_001;
    localparam logic [5:0] LAMPS_LO_VERDE   = 6'b001_100;
    localparam logic [5:0] LAMPS_LO_AMARELO = 6'b001_010;
    localparam logic [5:0] LAMPS_TODOS_VERM = 6'b001_001;

    estado_t     state_r;
    estado_t     state_next_s;
    logic [7:0]  timer_r;
    logic [7:0]  timer_next_s;
    logic [5:0]  lamps_r;
    logic [5:0]  lamps_next_s;
    logic        timer_fim_verde_s;
    logic        timer_fim_amarelo_s;
    logic        timer_fim_vermelho_s;

    // Lamp decode for one state.  Unused codes (6, 7) show the reset
    // pattern so each direction always has exactly one lamp lit.
    function automatic logic [5:0] decode_lamps(input estado_t st);
        logic [5:0] lamps;
        case (st)
            NS_VERDE:   lamps = LAMPS_NS_VERDE;
            NS_AMARELO: lamps = LAMPS_NS_AMARELO;
            VERM_A:     lamps = LAMPS_TODOS_VERM;
            LO_VERDE:   lamps = LAMPS_LO_VERDE;
            LO_AMARELO: lamps = LAMPS_LO_AMARELO;
            VERM_B:     lamps = LAMPS_TODOS_VERM;
            default:    lamps = LAMPS_LO_VERDE;
        endcase
        return lamps;
    endfunction

    // Phase-end qualifiers shared by the next-state logic.
    always_comb begin
        timer_fim_verde_s    = tick && (timer_r >= VERDE_LIM);
        timer_fim_amarelo_s  = tick && (timer_r == AMARELO_LIM);
        timer_fim_vermelho_s = tick && (timer_r == VERMELHO_LIM);
    end

    // Next-state logic.  Requests are only looked at on the decision edge
    // of a green phase; amber and all-red run to completion regardless.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            NS_VERDE: begin
                if (timer_fim_verde_s && l_o) begin
                    state_next_s = NS_AMARELO;
                end else begin
                    state_next_s = NS_VERDE;
                end
            end
            NS_AMARELO: begin
                if (timer_fim_amarelo_s) begin
`ifdef VERMELHO_TOTAL_EN
                    state_next_s = VERM_A;
`else
                    state_next_s = LO_VERDE;
`endif
                end else begin
                    state_next_s = NS_AMARELO;
                end
            end
            LO_VERDE: begin
                if (timer_fim_verde_s && n_s) begin
                    state_next_s = LO_AMARELO;
                end else begin
                    state_next_s = LO_VERDE;
                end
            end
            LO_AMARELO: begin
                if (timer_fim_amarelo_s) begin
`ifdef VERMELHO_TOTAL_EN
                    state_next_s = VERM_B;
`else
                    state_next_s = NS_VERDE;
`endif
                end else begin
                    state_next_s = LO_AMARELO;
                end
            end
`ifdef VERMELHO_TOTAL_EN
            VERM_A: begin
                if (timer_fim_vermelho_s) begin
                    state_next_s = LO_VERDE;
                end else begin
                    state_next_s = VERM_A;
                end
            end
            VERM_B: begin
                if (timer_fim_vermelho_s) begin
                    state_next_s = NS_VERDE;
                end else begin
                    state_next_s = VERM_B;
                end
            end
`else
            // All-red states are unreachable in this build; recover at once.
            VERM_A: begin
                if (timer_fim_vermelho_s) begin
                    state_next_s = LO_VERDE;
                end else begin
                    state_next_s = LO_VERDE;
                end
            end
            VERM_B: begin
                state_next_s = LO_VERDE;
            end
`endif
            default: begin
                state_next_s = LO_VERDE;
            end
        endcase
    end

    // Phase timer: restarts on every state change, otherwise counts
    // tick-enabled edges and saturates so a long green never wraps.
    always_comb begin
        timer_next_s = timer_r;
        if (state_next_s != state_r) begin
            timer_next_s = 8'd0;
        end else if (tick && (timer_r != TIMER_MAX)) begin
            timer_next_s = timer_r + 8'd1;
        end else begin
            timer_next_s = timer_r;
        end
    end

    // Lamps are registered from the next state so they always agree with
    // the state register and have no path from the inputs to the pins.
    always_comb begin
        lamps_next_s = decode_lamps(state_next_s);
    end

    // State, timer and lamp registers; reset forces the LO_VERDE phase
    // immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LO_VERDE;
            timer_r <= 8'd0;
            lamps_r <= LAMPS_LO_VERDE;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            lamps_r <= lamps_next_s;
        end
    end

    assign ns_verde    = lamps_r[5];
    assign ns_amarelo  = lamps_r[4];
    assign ns_vermelho = lamps_r[3];
    assign lo_verde    = lamps_r[2];
    assign lo_amarelo  = lamps_r[1];
    assign lo_vermelho = lamps_r[0];
    assign estado      = state_r;

endmodule

// File: tb/tb_semaforo_temporizado.sv
// -----------------------------------------------------------------------------
// tb_semaforo_temporizado
//
// Directed bench for semaforo_temporizado with T_VERDE_MIN=4, T_AMARELO=2,
// T_VERMELHO=1.  Expected values are hand-computed.  The all-red expectations
// follow whether VERMELHO_TOTAL_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_semaforo_temporizado;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       tick;
    logic       n_s;
    logic       l_o;
    logic       ns_verde;
    logic       ns_amarelo;
    logic       ns_vermelho;
    logic       lo_verde;
    logic       lo_amarelo;
    logic       lo_vermelho;
    logic [2:0] estado;

    int checks;
    int errors;

    localparam logic [5:0] L_NS_VERDE   = 6'b100_001;
    localparam logic [5:0] L_NS_AMARELO = 6'b010_001;
    localparam logic [5:0] L_LO_VERDE   = 6'b001_100;
    localparam logic [5:0] L_LO_AMARELO = 6'b001_010;
    localparam logic [5:0] L_VERM       = 6'b001_001;

    semaforo_temporizado #(
        .T_VERDE_MIN(4),
        .T_AMARELO  (2),
        .T_VERMELHO (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .n_s        (n_s),
        .l_o        (l_o),
        .ns_verde   (ns_verde),
        .ns_amarelo (ns_amarelo),
        .ns_vermelho(ns_vermelho),
        .lo_verde   (lo_verde),
        .lo_amarelo (lo_amarelo),
        .lo_vermelho(lo_vermelho),
        .estado     (estado)
    );

    // Gated clock so reset can be checked with no clock running.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lamps(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, ns_verde, ns_amarelo, ns_vermelho,
                  lo_verde, lo_amarelo, lo_vermelho}, {26'd0, exp});
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every-cycle safety monitor: never two greens, one lamp per direction.
    always @(negedge clk) begin
        chk("mon_two_greens", {31'd0, ns_verde & lo_verde}, 32'd0);
        chk("mon_ns_one_lamp", $countones({ns_verde, ns_amarelo, ns_vermelho}), 32'd1);
        chk("mon_lo_one_lamp", $countones({lo_verde, lo_amarelo, lo_vermelho}), 32'd1);
`ifndef VERMELHO_TOTAL_EN
        chk("mon_no_state5", {31'd0, (estado == 3'd5)}, 32'd0);
`endif
    end

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        tick   = 1'b1;
        n_s    = 1'b0;
        l_o    = 1'b0;
        rst    = 1'b0;
        #2;

        // Reset with no clock running.
        rst = 1'b1;
        #3;
        chk("rst_estado", {29'd0, estado}, 32'd3);
        chk_lamps("rst_lamps", L_LO_VERDE);

        // Full cycle: n_s held, l_o low.
        n_s    = 1'b1;
        l_o    = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("cyc_lo_verde_hold", {29'd0, estado}, 32'd3);
        end
        step();
        chk("cyc_e4_estado", {29'd0, estado}, 32'd4);
        chk_lamps("cyc_e4_lamps", L_LO_AMARELO);
        step();
        chk("cyc_e5_estado", {29'd0, estado}, 32'd4);
        step();
`ifdef VERMELHO_TOTAL_EN
        chk("cyc_e6_estado", {29'd0, estado}, 32'd5);
        chk_lamps("cyc_e6_lamps", L_VERM);
        step();
        chk("cyc_e7_estado", {29'd0, estado}, 32'd0);
`else
        chk("cyc_e6_estado", {29'd0, estado}, 32'd0);
`endif
        chk_lamps("cyc_ns_verde_lamps", L_NS_VERDE);

        // Mid-phase reset during NS_AMARELO (NS_VERDE timer at 0 now).
        n_s = 1'b0;
        l_o = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("mid_ns_verde_hold", {29'd0, estado}, 32'd0);
        end
        step();
        chk("mid_ns_amarelo", {29'd0, estado}, 32'd1);
        chk_lamps("mid_ns_amarelo_lamps", L_NS_AMARELO);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_estado", {29'd0, estado}, 32'd3);
        chk_lamps("mid_rst_lamps", L_LO_VERDE);
        chk("mid_rst_timer", {24'd0, dut.timer_r}, 32'd0);
        #2;
        rst = 1'b0;

        // Request pulse on edge 2 only: no effect, not latched.
        l_o = 1'b1;
        n_s = 1'b0;
        step();
        n_s = 1'b1;
        step();
        n_s = 1'b0;
        for (int e = 0; e < 260; e++) begin
            step();
        end
        chk("pulse_estado_hold", {29'd0, estado}, 32'd3);
        chk("pulse_timer_sat", {24'd0, dut.timer_r}, 32'd255);
        chk_lamps("pulse_lamps", L_LO_VERDE);
        l_o = 1'b0;
        n_s = 1'b1;
        step();
        chk("pulse_then_req", {29'd0, estado}, 32'd4);

        // Tick freeze in LO_AMARELO after one tick-enabled edge.
        n_s = 1'b0;
        step();
        chk("frz_first_tick", {29'd0, estado}, 32'd4);
        tick = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk("frz_estado", {29'd0, estado}, 32'd4);
        end
        chk("frz_timer", {24'd0, dut.timer_r}, 32'd1);
        tick = 1'b1;
        step();
`ifdef VERMELHO_TOTAL_EN
        chk("frz_end_estado", {29'd0, estado}, 32'd5);
        step();
        chk("frz_red_end", {29'd0, estado}, 32'd0);
`else
        chk("frz_end_estado", {29'd0, estado}, 32'd0);
`endif
        chk_lamps("frz_end_lamps", L_NS_VERDE);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/semaforo_temporizado.md
SEMAFORO_TEMPORIZADO -- requirements
Module: semaforo_temporizado

Interface
REQ-001 Parameter T_VERDE_MIN, default 8, minimum green duration in tick-enabled cycles, legal range 1..255.
REQ-002 Parameter T_AMARELO, default 3, amber duration in tick-enabled cycles, legal range 1..255.
REQ-003 Parameter T_VERMELHO, default 2, all-red clearance duration in tick-enabled cycles, legal range 1..255; used only when VERMELHO_TOTAL_EN is defined.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port tick, input, 1, time-base enable; timer advances only on edges where tick=1.
REQ-007 Port n_s, input, 1, north-south green request from the upstream Semaforo stage.
REQ-008 Port l_o, input, 1, east-west green request from the upstream Semaforo stage.
REQ-009 Ports ns_verde, ns_amarelo, ns_vermelho, output, 1 each, north-south lamp drives.
REQ-010 Ports lo_verde, lo_amarelo, lo_vermelho, output, 1 each, east-west lamp drives.
REQ-011 Port estado, output, 3, current state code.

Function
REQ-012 The block SHALL be a Moore FSM with states NS_VERDE=0, NS_AMARELO=1, VERM_A=2, LO_VERDE=3, LO_AMARELO=4, VERM_B=5; codes 6 and 7 SHALL go to LO_VERDE on the next edge.
REQ-013 All lamp outputs and estado SHALL be decoded from the state register only, with no combinational path from any input.
REQ-014 Lamp decode: in NS_VERDE, ns_verde=1 and lo_vermelho=1; in NS_AMARELO, ns_amarelo=1 and lo_vermelho=1; in LO_VERDE, lo_verde=1 and ns_vermelho=1; in LO_AMARELO, lo_amarelo=1 and ns_vermelho=1; in VERM_A and VERM_B, both reds=1; all other lamps 0.
REQ-015 An 8-bit timer SHALL clear to 0 on every state change and otherwise increment on edges with tick=1, saturating at 255.
REQ-016 Leave NS_VERDE for NS_AMARELO on an edge where tick=1, timer>=T_VERDE_MIN-1 and l_o=1; n_s is ignored in this state.
REQ-017 Leave LO_VERDE for LO_AMARELO on an edge where tick=1, timer>=T_VERDE_MIN-1 and n_s=1; l_o is ignored in this state.
REQ-018 Leave NS_AMARELO or LO_AMARELO on the edge where tick=1 and timer==T_AMARELO-1, regardless of n_s and l_o.
REQ-019 Requests SHALL NOT be latched: a request absent at the decision edge has no effect, and dropping a request during amber or all-red SHALL NOT abort the sequence.
REQ-020 Both greens SHALL never be 1 simultaneously, and each direction SHALL show exactly one lamp at all times.
REQ-021 With tick held at 1, a green phase lasts at least T_VERDE_MIN cycles and amber lasts exactly T_AMARELO cycles.

Reset
REQ-022 When rst=1, the block SHALL immediately, without waiting for clk, force state to LO_VERDE (estado=3) and timer to 0.
REQ-023 During reset, the outputs SHALL be lo_verde=1, ns_vermelho=1 and all other lamps 0, including when reset is asserted mid-phase.

Configuration
REQ-024 Macro VERMELHO_TOTAL_EN: when defined, NS_AMARELO SHALL go to VERM_A and LO_AMARELO SHALL go to VERM_B.
REQ-025 With VERMELHO_TOTAL_EN defined, VERM_A SHALL go to LO_VERDE and VERM_B SHALL go to NS_VERDE on the edge where tick=1 and timer==T_VERMELHO-1.
REQ-026 When VERMELHO_TOTAL_EN is undefined, NS_AMARELO SHALL go directly to LO_VERDE, LO_AMARELO SHALL go directly to NS_VERDE, and states 2 and 5 SHALL be unreachable; if entered, they SHALL go to LO_VERDE on the next edge.

Verification
All scenarios use T_VERDE_MIN=4, T_AMARELO=2, T_VERMELHO=1, tick=1 unless stated; edge 1 is the first rising edge after rst falls.
REQ-027 Reset: rst=1 with no clock running -> estado=3, lo_verde=1, ns_vermelho=1, all other lamps 0.
REQ-028 Full cycle with macro defined: n_s=1, l_o=0 from release -> estado 3 through edge 3, 4 after edge 4, 5 after edge 6, 0 after edge 7.
REQ-029 Full cycle without macro: same stimulus as REQ-028 -> estado 4 after edge 4, 0 after edge 6, and estado never equals 5.
REQ-030 Request pulse: n_s=1 only for edge 2 -> estado stays 3 indefinitely; then l_o=0, n_s=1 held -> transition on the next edge.
REQ-031 Tick freeze: tick=0 for 10 cycles in LO_AMARELO -> estado stays 4 and timer holds; amber ends 1 tick-enabled edge after tick returns to 1.
REQ-032 Mid-phase reset: rst pulsed between edges while estado=1 -> estado=3 before the next edge; every-cycle monitor confirms REQ-020 in all scenarios.
